// File: rtl/doppler_gate_sequencer.sv
// PRF-period scheduler: clears the demodulator, fires the TX burst, gates integration and captures I/Q.
// Optional `DOPPLER_DROP_COUNT_EN adds a saturating drop_count output for overrun events.
module doppler_gate_sequencer #(
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned TX_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [1:0]       cfg_freq_sel,
   input  logic [TX_W-1:0]  cfg_tx,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_gate,
   input  logic [CNT_W-1:0] cfg_prf,
   input  logic [63:0]      demod_out,
   output logic             demod_enable,
   output logic             demod_reset,
   output logic [1:0]       demod_freq_sel,
   output logic             tx_en,
   output logic [63:0]      res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             cfg_err,
`ifdef DOPPLER_DROP_COUNT_EN
   output logic [15:0]      drop_count,
`endif
   output logic             overrun
);

   localparam int unsigned SUM_W = CNT_W + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_TX, S_DELAY, S_INTEG, S_SETTLE, S_WAIT
   } state_t;

   state_t state, state_nx, after_c;

   logic [CNT_W-1:0] prf_cnt, prf_last;
   logic [CNT_W-1:0] b_tx, b_dly, b_int, b_set;
   logic [SUM_W-1:0] sum_dly_c, sum_int_c, sum_set_c, need_c;
   logic             cfg_ok_c, latch_c, period_end_c, capture_c;
   logic             tx_en_d, demod_reset_d, demod_enable_d, busy_d;

   // Phase boundaries are absolute PRF-counter values of the last cycle of each phase.
   always_comb begin
      sum_dly_c    = SUM_W'(cfg_tx) + SUM_W'(cfg_delay);
      sum_int_c    = sum_dly_c + SUM_W'(cfg_gate);
      sum_set_c    = sum_int_c + SUM_W'(PIPE_LAT);
      need_c       = sum_set_c + SUM_W'(1);
      cfg_ok_c     = (cfg_tx != '0) && (cfg_gate != '0) && (need_c <= SUM_W'(cfg_prf));
      latch_c      = (state == S_IDLE) && run;
      period_end_c = (prf_cnt == prf_last);
      capture_c    = (PIPE_LAT == 0) ? ((state == S_INTEG) && (prf_cnt == b_int))
                                     : ((state == S_SETTLE) && (prf_cnt == b_set));
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      after_c  = period_end_c ? (run ? S_CLEAR : S_IDLE) : S_WAIT;
      case (state)
         S_IDLE:   if (run && cfg_ok_c) state_nx = S_CLEAR;
         S_CLEAR:  state_nx = S_TX;
         S_TX:     if (prf_cnt == b_tx) state_nx = (b_dly == b_tx) ? S_INTEG : S_DELAY;
         S_DELAY:  if (prf_cnt == b_dly) state_nx = S_INTEG;
         S_INTEG:  if (prf_cnt == b_int) state_nx = (PIPE_LAT == 0) ? after_c : S_SETTLE;
         S_SETTLE: if (prf_cnt == b_set) state_nx = after_c;
         S_WAIT:   if (period_end_c) state_nx = run ? S_CLEAR : S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Output decode from next state so the gate flops line up with the state they represent.
   always_comb begin
      tx_en_d        = 1'b0;
      demod_reset_d  = 1'b0;
      demod_enable_d = 1'b0;
      busy_d         = 1'b0;
      tx_en_d        = (state_nx == S_TX);
      demod_reset_d  = (state_nx == S_CLEAR);
      demod_enable_d = (state_nx == S_INTEG) || (state_nx == S_SETTLE);
      busy_d         = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         tx_en        <= 1'b0;
         demod_reset  <= 1'b0;
         demod_enable <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         tx_en        <= tx_en_d;
         demod_reset  <= demod_reset_d;
         demod_enable <= demod_enable_d;
         busy         <= busy_d;
      end
   end

   // Period counter, config latch and one-deep result slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prf_cnt        <= '0;
         prf_last       <= '0;
         b_tx           <= '0;
         b_dly          <= '0;
         b_int          <= '0;
         b_set          <= '0;
         demod_freq_sel <= '0;
         cfg_err        <= 1'b0;
         overrun        <= 1'b0;
         res_data       <= '0;
         res_valid      <= 1'b0;
`ifdef DOPPLER_DROP_COUNT_EN
         drop_count     <= '0;
`endif
      end else begin
         if ((state_nx == S_CLEAR) || (state_nx == S_IDLE)) prf_cnt <= '0;
         else                                              prf_cnt <= prf_cnt + CNT_W'(1);

         if (latch_c) begin
            if (cfg_ok_c) begin
               b_tx           <= CNT_W'(cfg_tx);
               b_dly          <= CNT_W'(sum_dly_c);
               b_int          <= CNT_W'(sum_int_c);
               b_set          <= CNT_W'(sum_set_c);
               prf_last       <= cfg_prf - CNT_W'(1);
               demod_freq_sel <= cfg_freq_sel;
               cfg_err        <= 1'b0;
               overrun        <= 1'b0;
`ifdef DOPPLER_DROP_COUNT_EN
               drop_count     <= '0;
`endif
            end else begin
               cfg_err <= 1'b1;
            end
         end

         if (capture_c) begin
            if (!res_valid || res_ready) begin
               res_data  <= demod_out;
               res_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
`ifdef DOPPLER_DROP_COUNT_EN
               if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'(1);
`endif
            end
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_doppler_gate_sequencer.sv
// Bench for doppler_gate_sequencer: offset-within-period reference model plus directed literal checks.
module tb_doppler_gate_sequencer;

   localparam int unsigned PIPE_LAT = 2;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned TX_W     = 8;

   logic             clk = 1'b0;
   logic             reset, run, res_ready;
   logic [1:0]       cfg_freq_sel;
   logic [TX_W-1:0]  cfg_tx;
   logic [CNT_W-1:0] cfg_delay, cfg_gate, cfg_prf;
   logic [63:0]      demod_out;
   logic             demod_enable, demod_reset, tx_en, res_valid, busy, cfg_err, overrun;
   logic [1:0]       demod_freq_sel;
   logic [63:0]      res_data;
`ifdef DOPPLER_DROP_COUNT_EN
   logic [15:0]      drop_count;
`endif

   always #5 clk = ~clk;

   doppler_gate_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W), .TX_W(TX_W)) dut (
      .clk(clk), .reset(reset), .run(run), .cfg_freq_sel(cfg_freq_sel), .cfg_tx(cfg_tx),
      .cfg_delay(cfg_delay), .cfg_gate(cfg_gate), .cfg_prf(cfg_prf), .demod_out(demod_out),
      .demod_enable(demod_enable), .demod_reset(demod_reset), .demod_freq_sel(demod_freq_sel),
      .tx_en(tx_en), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .cfg_err(cfg_err),
`ifdef DOPPLER_DROP_COUNT_EN
      .drop_count(drop_count),
`endif
      .overrun(overrun)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a period is a run of cfg_prf cycles indexed by offset m_off from CLEAR.
   bit          m_known = 0, m_active = 0, m_err = 0, m_ovr = 0, m_valid = 0, m_cap = 0;
   int unsigned m_off = 0, l_tx = 0, l_dly = 0, l_gate = 0, l_prf = 0, m_drops = 0;
   logic [1:0]  m_fsel = '0;
   logic [63:0] m_data = '0;

   always @(posedge clk) begin
      if (!reset) begin
         m_known = 1; m_active = 0; m_off = 0; m_err = 0; m_ovr = 0;
         m_valid = 0; m_data = '0; m_drops = 0; m_fsel = '0;
      end else begin
         m_cap = m_active && (m_off == l_tx + l_dly + l_gate + PIPE_LAT);
         if (m_cap) begin
            if (!m_valid || res_ready) begin m_data = demod_out; m_valid = 1; end
            else begin m_ovr = 1; if (m_drops < 65535) m_drops++; end
         end else if (m_valid && res_ready) m_valid = 0;

         if (m_active) begin
            if (m_off == l_prf - 1) begin
               if (run) m_off = 0; else m_active = 0;
            end else m_off++;
         end else if (run) begin
            if (cfg_tx != 0 && cfg_gate != 0 &&
                1 + 32'(cfg_tx) + 32'(cfg_delay) + 32'(cfg_gate) + PIPE_LAT <= 32'(cfg_prf)) begin
               l_tx = 32'(cfg_tx); l_dly = 32'(cfg_delay); l_gate = 32'(cfg_gate); l_prf = 32'(cfg_prf);
               m_fsel = cfg_freq_sel; m_err = 0; m_ovr = 0; m_drops = 0;
               m_active = 1; m_off = 0;
            end else m_err = 1;
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (m_known) begin
         chk("demod_reset", 64'(demod_reset), 64'(m_active && m_off == 0));
         chk("tx_en", 64'(tx_en), 64'(m_active && m_off >= 1 && m_off <= l_tx));
         chk("demod_enable", 64'(demod_enable),
             64'(m_active && m_off >= 1 + l_tx + l_dly && m_off <= l_tx + l_dly + l_gate + PIPE_LAT));
         chk("busy", 64'(busy), 64'(m_active));
         chk("cfg_err", 64'(cfg_err), 64'(m_err));
         chk("overrun", 64'(overrun), 64'(m_ovr));
         chk("res_valid", 64'(res_valid), 64'(m_valid));
         chk("res_data", res_data, m_data);
         chk("demod_freq_sel", 64'(demod_freq_sel), 64'(m_fsel));
`ifdef DOPPLER_DROP_COUNT_EN
         chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
      demod_out = {$urandom, $urandom};
   endtask

   logic [63:0] dcap;

   initial begin
      reset = 1'b0; run = 1'b0; res_ready = 1'b1; demod_out = '0;
      cfg_freq_sel = 2'd1; cfg_tx = 8'd4; cfg_delay = 16'd10; cfg_gate = 16'd32; cfg_prf = 16'd100;
      dcap = '0;
      repeat (3) tick();
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst res_valid", 64'(res_valid), 64'(0));
      chk("rst tx_en", 64'(tx_en), 64'(0));
      chk("rst res_data", res_data, 64'(0));
      reset = 1'b1;
      repeat (2) tick();

      // Nominal periods, run dropped at cycle 20 of the second period.
      run = 1'b1;
      for (int c = 0; c <= 205; c++) begin
         tick();
         case (c)
            0:   chk("t1 clear", 64'(demod_reset), 64'(1));
            1:   chk("t1 tx first", 64'(tx_en), 64'(1));
            4:   chk("t1 tx last", 64'(tx_en), 64'(1));
            5:   chk("t1 tx off", 64'(tx_en), 64'(0));
            14:  chk("t1 en pre", 64'(demod_enable), 64'(0));
            15:  chk("t1 en first", 64'(demod_enable), 64'(1));
            48:  begin chk("t1 en last", 64'(demod_enable), 64'(1)); dcap = demod_out; end
            49:  begin
                    chk("t1 en off", 64'(demod_enable), 64'(0));
                    chk("t1 valid", 64'(res_valid), 64'(1));
                    chk("t1 data", res_data, dcap);
                 end
            50:  chk("t1 accepted", 64'(res_valid), 64'(0));
            100: chk("t1 period", 64'(demod_reset), 64'(1));
            148: chk("t5 en last", 64'(demod_enable), 64'(1));
            149: chk("t5 capture", 64'(res_valid), 64'(1));
            199: chk("t5 busy end", 64'(busy), 64'(1));
            200: chk("t5 idle", 64'(busy), 64'(0));
            205: chk("t5 no clear", 64'(demod_reset), 64'(0));
            default: ;
         endcase
         if (c == 120) run = 1'b0;
      end

      // Zero range-gate delay.
      cfg_delay = 16'd0; cfg_freq_sel = 2'd2; run = 1'b1;
      for (int c = 0; c <= 200; c++) begin
         tick();
         case (c)
            0:   chk("t2 clear", 64'(demod_reset), 64'(1));
            4:   chk("t2 en pre", 64'(demod_enable), 64'(0));
            5:   chk("t2 en first", 64'(demod_enable), 64'(1));
            38:  begin chk("t2 en last", 64'(demod_enable), 64'(1)); dcap = demod_out; end
            39:  begin
                    chk("t2 en off", 64'(demod_enable), 64'(0));
                    chk("t2 data", res_data, dcap);
                 end
            100: chk("t2 period", 64'(demod_reset), 64'(1));
            200: chk("t2 idle", 64'(busy), 64'(0));
            default: ;
         endcase
         if (c == 101) run = 1'b0;
      end

      // Over-long gate is rejected.
      cfg_delay = 16'd10; cfg_gate = 16'd90; cfg_freq_sel = 2'd3; run = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t3 cfg_err", 64'(cfg_err), 64'(1));
         chk("t3 busy", 64'(busy), 64'(0));
         chk("t3 tx_en", 64'(tx_en), 64'(0));
      end
      run = 1'b0; cfg_gate = 16'd32;
      tick();

      // Consumer stalls for two captures.
      res_ready = 1'b0; run = 1'b1;
      for (int c = 0; c <= 200; c++) begin
         tick();
         case (c)
            0:   chk("t4 err cleared", 64'(cfg_err), 64'(0));
            48:  dcap = demod_out;
            49:  begin
                    chk("t4 data1", res_data, dcap);
                    chk("t4 no overrun", 64'(overrun), 64'(0));
                 end
            149: begin
                    chk("t4 overrun", 64'(overrun), 64'(1));
                    chk("t4 held", res_data, dcap);
                    chk("t4 valid", 64'(res_valid), 64'(1));
`ifdef DOPPLER_DROP_COUNT_EN
                    chk("t4 drop_count", 64'(drop_count), 64'(1));
`endif
                 end
            151: chk("t4 accepted", 64'(res_valid), 64'(0));
            200: chk("t4 sticky", 64'(overrun), 64'(1));
            default: ;
         endcase
         if (c == 150) begin res_ready = 1'b1; run = 1'b0; end
      end

      // Reset during integration, then restart.
      run = 1'b1;
      for (int c = 0; c <= 140; c++) begin
         tick();
         case (c)
            30:  chk("t6 integ", 64'(demod_enable), 64'(1));
            31, 32: begin
                    chk("t6 en", 64'(demod_enable), 64'(0));
                    chk("t6 tx", 64'(tx_en), 64'(0));
                    chk("t6 busy", 64'(busy), 64'(0));
                    chk("t6 fsel", 64'(demod_freq_sel), 64'(0));
                 end
            33:  chk("t6 restart", 64'(demod_reset), 64'(1));
            34:  chk("t6 tx", 64'(tx_en), 64'(1));
            140: chk("t6 idle", 64'(busy), 64'(0));
            default: ;
         endcase
         if (c == 30) reset = 1'b0;
         if (c == 32) reset = 1'b1;
         if (c == 40) run = 1'b0;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/doppler_gate_sequencer.md
Name: doppler_gate_sequencer

Overview:
Pulse-repetition scheduler for the quadrature demodulator/accumulator datapath. Per PRF period it:
- clears the demodulator,
- fires the transmit burst,
- waits the range-gate delay,
- holds demodulator enable for the gate length plus pipeline settle,
- captures the 64-bit I/Q accumulation into a one-deep output register with a valid/ready handshake.

Sits between the host configuration registers, the TX driver and the demodulator instance.

Parameters:
PIPE_LAT, 2, cycles enable stays high after gate end before capture (multiplier + adder latency)
CNT_W, 16, width of delay/gate/PRF counters and config ports
TX_W, 8, width of TX burst length config

Ports:
clk  in  1  system clock (64 MHz sampling clock)
reset  in  1  synchronous, active-low reset
run  in  1  level; 1 = sequence PRF periods continuously
cfg_freq_sel  in  2  demod LO select, passed through
cfg_tx  in  TX_W  TX burst length in cycles, >=1
cfg_delay  in  CNT_W  range-gate delay in cycles, 0 allowed
cfg_gate  in  CNT_W  gate length in cycles, >=1
cfg_prf  in  CNT_W  PRF period in cycles
demod_out  in  64  demodulator result, {Q[63:32], I[31:0]}
demod_enable  out  1  demodulator enable
demod_reset  out  1  demodulator reset/LUT realign pulse
demod_freq_sel  out  2  registered cfg_freq_sel
tx_en  out  1  transmit burst gate
res_data  out  64  captured result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
cfg_err  out  1  last start attempt rejected
overrun  out  1  sticky, result dropped

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; all outputs 0; counters 0; res_data 0. Takes effect immediately, mid-period included. tx_en and demod_enable are 0 on the next cycle.
- Config is latched in IDLE on the cycle run=1 is seen. Config changes are ignored until the sequencer returns to IDLE.
- Config check at latch: valid iff cfg_tx>=1, cfg_gate>=1 and 1+cfg_tx+cfg_delay+cfg_gate+PIPE_LAT <= cfg_prf. Sums are computed CNT_W+2 bits wide, so there is no wrap.
  - Invalid: set cfg_err=1 and stay in IDLE. cfg_err stays 1 until the next valid latch or reset.
  - Valid: clear cfg_err and overrun, go to CLEAR.
- PRF counter is 0 on CLEAR entry and increments every cycle. A period is exactly cfg_prf cycles.
- States, all outputs registered (state decoded to flops, no combinational outputs):
  - CLEAR, 1 cycle: demod_reset=1, demod_enable=0.
  - TX, cfg_tx cycles: tx_en=1.
  - DELAY, cfg_delay cycles; skipped when 0.
  - INTEG, cfg_gate cycles: demod_enable=1.
  - SETTLE, PIPE_LAT cycles: demod_enable=1. On the clk edge ending the last SETTLE cycle, demod_out is captured (see output slot).
  - WAIT: all gates 0, until PRF counter = cfg_prf-1. Then go to CLEAR if run=1, else IDLE.
- run deasserted mid-period: the current period completes, including capture. Then IDLE.
- Output slot:
  - res_valid=1 the cycle after capture.
  - Handshake completes on a cycle with res_valid & res_ready; res_valid drops the next cycle.
  - res_data is stable while res_valid=1.
  - Capture while res_valid=1 and not accepted that same cycle: keep the old data, drop the new, set overrun=1.
  - Capture in the same cycle as acceptance: load the new data, res_valid stays 1, no overrun.
- demod_freq_sel is updated only at config latch.

Optional Feature:
DOPPLER_DROP_COUNT_EN
- Defined: adds output drop_count (16 bits).
  - Increments on each overrun event and saturates at 0xFFFF.
  - Cleared on valid config latch and on reset.
- Undefined: port and counter are absent; overrun flag only.

Test Plan:
1. cfg_tx=4, delay=10, gate=32, prf=100, PIPE_LAT=2, run=1, res_ready=1. With CLEAR at cycle 0, required:
   - demod_reset at cycle 0;
   - tx_en cycles 1-4;
   - demod_enable cycles 15-48;
   - res_valid=1 at cycle 49 with res_data = demod_out sampled at end of cycle 48;
   - next CLEAR at cycle 100.
2. Same config, cfg_delay=0 -> demod_enable cycles 5-38, capture end of cycle 38, period still 100.
3. cfg_gate=90, others as test 1 (1+4+10+90+2=107>100) -> cfg_err=1, busy=0, no tx_en ever.
4. res_ready=0 for 2 periods -> first result held unchanged, overrun=1 after second capture, drop_count=1 when DOPPLER_DROP_COUNT_EN is defined.
5. run dropped at cycle 20 of a period -> demod_enable still runs through cycle 48, capture occurs, busy=0 from cycle 100, no further CLEAR.
6. reset=0 asserted at cycle 30 (during INTEG) -> next cycle all outputs 0, state IDLE. After release with run=1, a new CLEAR occurs on the first cycle.
